// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
// The state encoding and the pointer-ordered winner search live here.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  // Returns the first asserted request at or after ptr, wrapping modulo N_REQ.
  // With no request set the result is ptr, which callers gate with |req.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] idx;
    rr_pick = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting blocks and rr_arbiter_4.
// The slave modport is the arbiter side; master is the requester side.
interface rr_arbiter_4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             en;
  logic             a1;
  logic             a0;
  logic [N_REQ-1:0] gnt;
  logic             timeout;

  modport master (output req, input en, a1, a0, gnt, timeout);
  modport slave  (input req, output en, a1, a0, gnt, timeout);

endinterface

// File: rtl/decoder_2_4.sv
// 2-to-4 decoder with enable: z[{a1,a0}] = en, every other bit 0.
module decoder_2_4 (
  input  logic       en,
  input  logic       a1,
  input  logic       a0,
  output logic [3:0] z
);

  always_comb begin
    z = 4'b0000;
    z[{a1, a0}] = en;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a registered grant index and a one-hot
// grant decode. Define ARB_TIMEOUT_EN to revoke grants held for HOLD_MAX cycles.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  rr_arbiter_4_if.slave bus
);

  if ((HOLD_MAX < 2) || (HOLD_MAX > 255)) begin : g_hold_range
    $error("rr_arbiter_4: HOLD_MAX must lie in 2..255");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             en_q, en_d;
  logic [IDX_W-1:0] winner;
  logic             any_req;
  logic             rel_req;
  logic             expire;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign expire = (cnt_q == HOLD_LAST);
`else
  assign expire = 1'b0;
`endif

  assign winner  = rr_pick(bus.req, ptr_q);
  assign any_req = |bus.req;
  assign rel_req = ~bus.req[idx_q];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    en_d    = en_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      // IDLE and GAP both arbitrate; GAP differs only in being entered for one cycle.
      IDLE, GAP: begin
        if (any_req) begin
          state_d = GRANT;
          idx_d   = winner;
          en_d    = 1'b1;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end else begin
          state_d = IDLE;
          en_d    = 1'b0;
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        cnt_d = sat_inc(cnt_q);
`endif
        if (rel_req || expire) begin
          state_d = GAP;
          en_d    = 1'b0;
          ptr_d   = idx_q + IDX_W'(1);
`ifdef ARB_TIMEOUT_EN
          // A voluntary release in the expiry cycle is not a revocation.
          timeout_d = ~rel_req;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      en_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.en = en_q;
  assign bus.a1 = idx_q[1];
  assign bus.a0 = idx_q[0];
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  decoder_2_4 u_dec (
    .en (en_q),
    .a1 (idx_q[1]),
    .a0 (idx_q[0]),
    .z  (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4; observed word is {timeout, en, a1, a0, gnt}.
// Timeout steps are compiled in when ARB_TIMEOUT_EN is defined (HOLD_MAX = 4).
module tb_rr_arbiter_4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ev(input logic to, input logic e, input int idx,
                                    input logic [3:0] g);
    return {to, e, 2'(idx), g};
  endfunction

  task automatic chk(input string tag, input logic [7:0] expv);
    logic [7:0] got;
    got = {bus.timeout, bus.en, bus.a1, bus.a0, bus.gnt};
    n_tests++;
    assert (got === expv)
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, got, expv);
    end
  endtask

  // Drive req at a falling edge, let one rising edge sample it, check at the next falling edge.
  task automatic cyc(input logic [3:0] r, input string tag, input logic [7:0] expv);
    bus.req = r;
    @(negedge clk);
    chk(tag, expv);
  endtask

  initial begin
    logic [3:0] drop;
    int nxt;
    bus.req = 4'b1111;
    #1 rst_n = 1'b0;
    #1 chk("reset_async", ev(0, 0, 0, 4'b0000));
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", ev(0, 0, 0, 4'b0000));
    end
    rst_n = 1'b1;

    cyc(4'b0000, "idle",          ev(0, 0, 0, 4'b0000));
    cyc(4'b0100, "single_grant",  ev(0, 1, 2, 4'b0100));
    cyc(4'b0100, "single_hold",   ev(0, 1, 2, 4'b0100));
    cyc(4'b0000, "single_gap",    ev(0, 0, 2, 4'b0000));
    cyc(4'b0000, "single_idle",   ev(0, 0, 2, 4'b0000));

    cyc(4'b1001, "wrap_first3",   ev(0, 1, 3, 4'b1000));
    cyc(4'b0001, "wrap_gap",      ev(0, 0, 3, 4'b0000));
    cyc(4'b0001, "wrap_then0",    ev(0, 1, 0, 4'b0001));
    cyc(4'b0000, "wrap_gap2",     ev(0, 0, 0, 4'b0000));
    cyc(4'b0000, "wrap_idle",     ev(0, 0, 0, 4'b0000));

    cyc(4'b0011, "pre_rst_grant", ev(0, 1, 1, 4'b0010));
    #2 rst_n = 1'b0;
    #1 chk("midgrant_rst_async", ev(0, 0, 0, 4'b0000));
    @(negedge clk);
    chk("midgrant_rst_hold", ev(0, 0, 0, 4'b0000));
    rst_n = 1'b1;
    cyc(4'b0011, "post_rst_ptr0", ev(0, 1, 0, 4'b0001));

    cyc(4'b1111, "fair_hold0", ev(0, 1, 0, 4'b0001));
    cyc(4'b1111, "fair_hold0", ev(0, 1, 0, 4'b0001));
    for (int k = 0; k < 4; k++) begin
      drop = 4'b1111 & ~(4'b0001 << k);
      nxt = (k + 1) % 4;
      cyc(drop, "fair_gap", ev(0, 0, k, 4'b0000));
      cyc(4'b1111, "fair_next", ev(0, 1, nxt, 4'b0001 << nxt));
      cyc(4'b1111, "fair_hold", ev(0, 1, nxt, 4'b0001 << nxt));
      cyc(4'b1111, "fair_hold", ev(0, 1, nxt, 4'b0001 << nxt));
    end

`ifdef ARB_TIMEOUT_EN
    cyc(4'b1111, "to_hold4",      ev(0, 1, 0, 4'b0001));
    cyc(4'b1111, "to_fire0",      ev(1, 0, 0, 4'b0000));
    cyc(4'b0011, "to_grant1",     ev(0, 1, 1, 4'b0010));
    repeat (3) cyc(4'b0011, "to_hold1", ev(0, 1, 1, 4'b0010));
    cyc(4'b0011, "to_fire1",      ev(1, 0, 1, 4'b0000));
    cyc(4'b0011, "to_grant0",     ev(0, 1, 0, 4'b0001));
    repeat (3) cyc(4'b0011, "to_hold0", ev(0, 1, 0, 4'b0001));
    cyc(4'b0010, "to_drop_same_cycle", ev(0, 0, 0, 4'b0000));
    cyc(4'b0010, "solo_grant",    ev(0, 1, 1, 4'b0010));
    repeat (3) cyc(4'b0010, "solo_hold", ev(0, 1, 1, 4'b0010));
    cyc(4'b0010, "solo_fire",     ev(1, 0, 1, 4'b0000));
    cyc(4'b0010, "solo_regain",   ev(0, 1, 1, 4'b0010));
    cyc(4'b0000, "solo_gap",      ev(0, 0, 1, 4'b0000));
    cyc(4'b0000, "solo_idle",     ev(0, 0, 1, 4'b0000));
`else
    repeat (20) cyc(4'b1111, "no_timeout_hold", ev(0, 1, 0, 4'b0001));
    cyc(4'b0000, "long_gap",      ev(0, 0, 0, 4'b0000));
    cyc(4'b0000, "long_idle",     ev(0, 0, 0, 4'b0000));
    cyc(4'b0110, "after_long",    ev(0, 1, 1, 4'b0010));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
